row_readout_seq: RTL

Row readout sequencer for the image sensor. On each frame-start pulse it walks the sensor rows 0..rowlast. For every row it drives the row-address / row-start / load-shift / data-read strobe sequence toward the sensor pins. It also produces line/frame valid flags for the pixel datapath that packs the 10 parallel pixel taps. It sits between the sync generator (frame pulse) and the sensor pin registers, and replaces ad-hoc strobe generation.

---
 rtl/row_readout_seq_if.sv | 25 ++
 rtl/row_readout_seq.sv | 133 +++++++++++++
 2 files changed

// File: rtl/row_readout_seq_if.sv
// Signal bundle between the sensor row-readout sequencer and its surroundings:
// frame control in, sensor strobes and datapath valid flags out.
interface row_readout_seq_if;
  logic       en;
  logic       fstart;
  logic [9:0] rowlast;
  logic [9:0] arow;
  logic       rstrt;
  logic       ldshft;
  logic       enrd;
  logic       lval;
  logic       fval;
  logic       busy;
  logic       ovr;

  modport master (
    output en, fstart, rowlast,
    input  arow, rstrt, ldshft, enrd, lval, fval, busy, ovr
  );

  modport slave (
    input  en, fstart, rowlast,
    output arow, rstrt, ldshft, enrd, lval, fval, busy, ovr
  );
endinterface

// File: rtl/row_readout_seq.sv
// Row readout sequencer: on each accepted frame-start it walks rows 0..rlast,
// emitting ROW_STRT / settle / LD_SHIFT / DATA_READ / gap per row.
module row_readout_seq #(
  parameter int TSTRT = 4,
  parameter int TSET  = 8,
  parameter int TLD   = 2,
  parameter int RDLEN = 128
) (
  input  logic              clk,
  input  logic              init,
  row_readout_seq_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, RSTRT, SETTLE, LDSH, READ, GAP} state_t;

  localparam logic [9:0] STRT_LAST = 10'(TSTRT - 1);
  localparam logic [9:0] SET_LAST  = 10'(TSET - 1);
  localparam logic [9:0] LD_LAST   = 10'(TLD - 1);
  localparam logic [9:0] RD_LAST   = 10'(RDLEN - 1);

  state_t     state, state_n;
  logic [9:0] phase, phase_n;
  logic [9:0] row, row_n;
  logic [9:0] rlast, rlast_n;
  logic       ovr_n;

  logic [9:0] arow_q;
  logic       rstrt_q, ldshft_q, enrd_q, active_q, ovr_q;

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      state    <= IDLE;
      phase    <= '0;
      row      <= '0;
      rlast    <= '0;
      arow_q   <= '0;
      rstrt_q  <= 1'b0;
      ldshft_q <= 1'b0;
      enrd_q   <= 1'b0;
      active_q <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state    <= state_n;
      phase    <= phase_n;
      row      <= row_n;
      rlast    <= rlast_n;
      rstrt_q  <= (state_n == RSTRT);
      ldshft_q <= (state_n == LDSH);
      enrd_q   <= (state_n == READ);
      active_q <= (state_n != IDLE);
      ovr_q    <= ovr_n;
      if (state_n == RSTRT && state != RSTRT) begin
        arow_q <= row_n;
      end
    end
  end

  always_comb begin
    state_n = state;
    phase_n = phase + 10'd1;
    row_n   = row;
    rlast_n = rlast;
    ovr_n   = 1'b0;

    case (state)
      IDLE: begin
        phase_n = '0;
        if (bus.en && bus.fstart) begin
          state_n = RSTRT;
          rlast_n = bus.rowlast;
          row_n   = '0;
        end
      end
      RSTRT: begin
        if (phase == STRT_LAST) begin
          state_n = SETTLE;
          phase_n = '0;
        end
      end
      SETTLE: begin
        if (phase == SET_LAST) begin
          state_n = LDSH;
          phase_n = '0;
        end
      end
      LDSH: begin
        if (phase == LD_LAST) begin
          state_n = READ;
          phase_n = '0;
        end
      end
      READ: begin
        if (phase == RD_LAST) begin
          state_n = GAP;
          phase_n = '0;
        end
      end
      GAP: begin
        phase_n = '0;
        if (row == rlast) begin
          state_n = IDLE;
        end else begin
          row_n   = row + 10'd1;
          state_n = RSTRT;
        end
      end
      default: begin
        state_n = IDLE;
        phase_n = '0;
      end
    endcase

    // A frame in flight rejects new starts and is aborted when the detector is disabled.
    if (state != IDLE) begin
      ovr_n = bus.fstart;
      if (!bus.en) begin
        state_n = IDLE;
        phase_n = '0;
      end
    end
  end

  assign bus.arow   = arow_q;
  assign bus.rstrt  = rstrt_q;
  assign bus.ldshft = ldshft_q;
  assign bus.enrd   = enrd_q;
  assign bus.lval   = enrd_q;
  assign bus.fval   = active_q;
  assign bus.busy   = active_q;
  assign bus.ovr    = ovr_q;

endmodule
